// File: rtl/pong_game_ctrl_pkg.sv
// Shared state encodings, playfield geometry and small arithmetic helpers
// for the Pong game sequencer.
package pong_game_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_POINT = 3'd3,
    ST_OVER  = 3'd4
  } state_t;

  localparam logic [9:0] H_ACTIVE    = 10'd640;
  localparam logic [9:0] V_ACTIVE    = 10'd480;
  localparam logic [9:0] BALL_SIZE   = 10'd5;
  localparam logic [9:0] PADDLE_W    = 10'd10;
  localparam logic [9:0] PADDLE_H    = 10'd100;
  localparam logic [9:0] P1_X        = 10'd15;
  localparam logic [9:0] P2_X        = 10'd615;
  localparam logic [9:0] TOP_LIM     = 10'd10;
  localparam logic [9:0] BOT_LIM     = 10'd470;
  localparam logic [9:0] PADDLE_STEP = 10'd4;
  localparam logic [9:0] BALL_SPEED  = 10'd2;
  localparam logic [5:0] SERVE_FRAMES = 6'd60;
  localparam logic [3:0] WIN_SCORE    = 4'd7;

  localparam logic [9:0] BALL_X0    = (H_ACTIVE - BALL_SIZE) / 10'd2;
  localparam logic [9:0] BALL_Y0    = (V_ACTIVE - BALL_SIZE) / 10'd2;
  localparam logic [9:0] PADDLE_Y0  = (V_ACTIVE - PADDLE_H) / 10'd2;
  localparam logic [9:0] PADDLE_MAX = BOT_LIM - PADDLE_H;
  localparam logic [9:0] BALL_Y_MAX = BOT_LIM - BALL_SIZE;
  localparam logic [9:0] P1_FACE    = P1_X + PADDLE_W;
  localparam logic [9:0] P2_FACE    = P2_X - BALL_SIZE;

  // Widen to 11 bits so sums used in compares cannot wrap.
  function automatic logic [10:0] ext(input logic [9:0] v);
    return {1'b0, v};
  endfunction

  function automatic logic [9:0] paddle_next(input logic [9:0] y,
                                             input logic up_n,
                                             input logic down_n);
    logic [9:0] res;
    if (!up_n && down_n) begin
      if (ext(y) <= ext(TOP_LIM) + ext(PADDLE_STEP)) res = TOP_LIM;
      else res = y - PADDLE_STEP;
    end else if (up_n && !down_n) begin
      if (ext(y) + ext(PADDLE_STEP) >= ext(PADDLE_MAX)) res = PADDLE_MAX;
      else res = y + PADDLE_STEP;
    end else begin
      res = y;
    end
    return res;
  endfunction

  function automatic logic [3:0] score_inc(input logic [3:0] s);
    return (s >= WIN_SCORE) ? WIN_SCORE : s + 4'd1;
  endfunction

endpackage

// File: rtl/pong_game_ctrl_frame_tick.sv
// Per-frame tick from the falling edge of vsync, plus the serve hold counter
// that releases the ball after a fixed number of frames.
module pong_game_ctrl_frame_tick
  import pong_game_ctrl_pkg::*;
(
  input  logic clk25,
  input  logic rst_n,
  input  logic vga_vs,
  input  logic serve_active,
  output logic tick,
  output logic serve_done
);

  logic       vs_prev_r;
  logic [5:0] serve_cnt_r;

  assign serve_done = tick & serve_active & (serve_cnt_r == SERVE_FRAMES - 6'd1);

  // Edge detector and serve frame counter.
  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      vs_prev_r   <= 1'b0;
      tick        <= 1'b0;
      serve_cnt_r <= 6'd0;
    end else begin
      vs_prev_r <= vga_vs;
      tick      <= vs_prev_r & ~vga_vs;
      if (!serve_active || serve_done) begin
        serve_cnt_r <= 6'd0;
      end else if (tick) begin
        serve_cnt_r <= serve_cnt_r + 6'd1;
      end
    end
  end

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: owns ball, paddles, scores and game state, advancing
// once per video frame so the pixel logic only ever sees stable coordinates.
module pong_game_ctrl
  import pong_game_ctrl_pkg::*;
(
  input  logic       clk25,
  input  logic       rst_n,
  input  logic       vga_vs,
  input  logic       btn_1_up,
  input  logic       btn_1_down,
  input  logic       btn_2_up,
  input  logic       btn_2_down,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic [9:0] paddle_1_y,
  output logic [9:0] paddle_2_y,
  output logic [3:0] score_1,
  output logic [3:0] score_2,
  output logic [2:0] game_state,
  output logic       game_over,
  output logic       winner
);

  state_t     state_r;
  logic       dx_neg_r, dy_neg_r, scorer_r, rel_r, pend_r;
  logic       tick_s, serve_done_s, all_rel_s, press_s;
  logic       overlap_1_s, overlap_2_s;
  logic [9:0] x_nxt_s, y_nxt_s, p1_nxt_s, p2_nxt_s;
  logic       dx_nxt_s, dy_nxt_s, miss_1_s, miss_2_s;

  pong_game_ctrl_frame_tick u_frame_tick (
    .clk25        (clk25),
    .rst_n        (rst_n),
    .vga_vs       (vga_vs),
    .serve_active (state_r == ST_SERVE),
    .tick         (tick_s),
    .serve_done   (serve_done_s)
  );

  assign game_state = state_r;
  assign all_rel_s  = btn_1_up & btn_1_down & btn_2_up & btn_2_down;
  // A press edge is remembered until the next tick so it cannot be lost between frames.
  assign press_s    = pend_r | (rel_r & ~all_rel_s);
  assign p1_nxt_s   = paddle_next(paddle_1_y, btn_1_up, btn_1_down);
  assign p2_nxt_s   = paddle_next(paddle_2_y, btn_2_up, btn_2_down);

  assign overlap_1_s = (ext(ball_y) + ext(BALL_SIZE) > ext(paddle_1_y)) &&
                       (ext(ball_y) < ext(paddle_1_y) + ext(PADDLE_H));
  assign overlap_2_s = (ext(ball_y) + ext(BALL_SIZE) > ext(paddle_2_y)) &&
                       (ext(ball_y) < ext(paddle_2_y) + ext(PADDLE_H));

  // Ball motion for one frame, judged against the current paddle positions.
  always_comb begin
    y_nxt_s  = ball_y;
    dy_nxt_s = dy_neg_r;
    x_nxt_s  = ball_x;
    dx_nxt_s = dx_neg_r;
    miss_1_s = 1'b0;
    miss_2_s = 1'b0;
    if (dy_neg_r) begin
      if (ext(ball_y) <= ext(TOP_LIM) + ext(BALL_SPEED)) begin
        y_nxt_s  = TOP_LIM;
        dy_nxt_s = 1'b0;
      end else begin
        y_nxt_s = ball_y - BALL_SPEED;
      end
    end else begin
      if (ext(ball_y) + ext(BALL_SPEED) >= ext(BALL_Y_MAX)) begin
        y_nxt_s  = BALL_Y_MAX;
        dy_nxt_s = 1'b1;
      end else begin
        y_nxt_s = ball_y + BALL_SPEED;
      end
    end
    if (dx_neg_r) begin
      if ((ext(ball_x) <= ext(P1_FACE) + ext(BALL_SPEED)) &&
          (ext(ball_x) >= ext(P1_FACE)) && overlap_1_s) begin
        x_nxt_s  = P1_FACE;
        dx_nxt_s = 1'b0;
      end else if (ext(ball_x) <= ext(BALL_SPEED)) begin
        miss_1_s = 1'b1;
      end else begin
        x_nxt_s = ball_x - BALL_SPEED;
      end
    end else begin
      if ((ext(ball_x) + ext(BALL_SPEED) >= ext(P2_FACE)) &&
          (ext(ball_x) <= ext(P2_FACE)) && overlap_2_s) begin
        x_nxt_s  = P2_FACE;
        dx_nxt_s = 1'b1;
      end else if (ext(ball_x) + ext(BALL_SIZE) + ext(BALL_SPEED) >= ext(H_ACTIVE)) begin
        miss_2_s = 1'b1;
      end else begin
        x_nxt_s = ball_x + BALL_SPEED;
      end
    end
  end

  // Game FSM with all registered outputs; state only moves on a frame tick.
  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      ball_x     <= BALL_X0;
      ball_y     <= BALL_Y0;
      paddle_1_y <= PADDLE_Y0;
      paddle_2_y <= PADDLE_Y0;
      score_1    <= 4'd0;
      score_2    <= 4'd0;
      dx_neg_r   <= 1'b0;
      dy_neg_r   <= 1'b0;
      game_over  <= 1'b0;
      winner     <= 1'b0;
      scorer_r   <= 1'b0;
      rel_r      <= 1'b0;
      pend_r     <= 1'b0;
    end else begin
      rel_r  <= all_rel_s;
      pend_r <= ((state_r == ST_IDLE) || (state_r == ST_OVER)) ? press_s : 1'b0;
      if (tick_s) begin
        case (state_r)
          ST_IDLE: begin
            if (press_s) begin
              state_r <= ST_SERVE;
              score_1 <= 4'd0;
              score_2 <= 4'd0;
              ball_x  <= BALL_X0;
              ball_y  <= BALL_Y0;
              pend_r  <= 1'b0;
            end
          end
          ST_SERVE: begin
            paddle_1_y <= p1_nxt_s;
            paddle_2_y <= p2_nxt_s;
            if (serve_done_s) state_r <= ST_PLAY;
          end
          ST_PLAY: begin
            paddle_1_y <= p1_nxt_s;
            paddle_2_y <= p2_nxt_s;
            ball_y     <= y_nxt_s;
            dy_neg_r   <= dy_nxt_s;
            if (miss_1_s) begin
              state_r  <= ST_POINT;
              score_2  <= score_inc(score_2);
              scorer_r <= 1'b1;
            end else if (miss_2_s) begin
              state_r  <= ST_POINT;
              score_1  <= score_inc(score_1);
              scorer_r <= 1'b0;
            end else begin
              ball_x   <= x_nxt_s;
              dx_neg_r <= dx_nxt_s;
            end
          end
          ST_POINT: begin
            ball_x   <= BALL_X0;
            ball_y   <= BALL_Y0;
            dx_neg_r <= scorer_r;
            if ((scorer_r ? score_2 : score_1) == WIN_SCORE) begin
              state_r   <= ST_OVER;
              game_over <= 1'b1;
              winner    <= scorer_r;
            end else begin
              state_r <= ST_SERVE;
            end
          end
          ST_OVER: begin
            if (press_s) begin
              state_r   <= ST_IDLE;
              game_over <= 1'b0;
              pend_r    <= 1'b0;
            end
          end
          default: state_r <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
